// File: rtl/mux21_behavioral.sv
// Behavioral 2:1 selector with a monitoring shadow stage.
// The shadow registers observe Y only; they never feed back into the mux path.
module mux21_behavioral #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             S0,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             chg,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] r_yq;
  logic             r_chg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_sat;

  // Conditional operator merges I0/I1 bitwise when S0 is X/Z in simulation.
  assign Y      = S0 ? I1 : I0;
  assign w_diff = (Y != r_yq);
  assign w_sat  = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_yq  <= '0;
      r_chg <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_yq  <= Y;
      r_chg <= w_diff;
      if (w_diff && !w_sat)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Y_q     = r_yq;
  assign chg     = r_chg;
  assign chg_cnt = r_cnt;

endmodule

// File: tb/tb_mux21_behavioral.sv
// Bench for mux21_behavioral: combinational checks plus a queued scoreboard
// for the shadow stage across three parameterizations.
module tb_mux21_behavioral;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a0, a1, as, ay, ayq, achg;
  logic [15:0] acnt;
  logic b0, b1, bs, by, byq, bchg;
  logic [1:0] bcnt;
  logic [7:0] c0, c1, cy, cyq;
  logic cs, cchg;
  logic [15:0] ccnt;

  mux21_behavioral #(.WIDTH(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .I0(a0), .I1(a1), .S0(as),
    .Y(ay), .Y_q(ayq), .chg(achg), .chg_cnt(acnt));
  mux21_behavioral #(.WIDTH(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .I0(b0), .I1(b1), .S0(bs),
    .Y(by), .Y_q(byq), .chg(bchg), .chg_cnt(bcnt));
  mux21_behavioral #(.WIDTH(8), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .I0(c0), .I1(c1), .S0(cs),
    .Y(cy), .Y_q(cyq), .chg(cchg), .chg_cnt(ccnt));

  int checks = 0, errors = 0;
  int yev = 0, apulse = 0;
  always @(ay) yev++;

  logic [31:0] sb[$];
  logic [31:0] qa = 0, ca = 0, na = 0;
  logic [31:0] qb = 0, cb = 0, nb = 0;
  logic [31:0] qc = 0, cc = 0, nc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the shadow stage at one rising edge.
  task automatic mdl(input logic [31:0] y, input logic [31:0] max,
                     inout logic [31:0] q, inout logic [31:0] c, inout logic [31:0] n);
    if (rst) begin
      q = 0; c = 0; n = 0;
    end else begin
      c = (y != q) ? 1 : 0;
      if (c == 1 && n < max) n = n + 1;
      q = y;
    end
  endtask

  task automatic tick();
    logic [31:0] ya, yb, yc;
    ya = {31'd0, (as ? a1 : a0)};
    yb = {31'd0, (bs ? b1 : b0)};
    yc = {24'd0, (cs ? c1 : c0)};
    mdl(ya, 32'hFFFF, qa, ca, na);
    mdl(yb, 32'd3,    qb, cb, nb);
    mdl(yc, 32'hFFFF, qc, cc, nc);
    sb.push_back(qa); sb.push_back(ca); sb.push_back(na);
    sb.push_back(qb); sb.push_back(cb); sb.push_back(nb);
    sb.push_back(qc); sb.push_back(cc); sb.push_back(nc);
    @(posedge clk);
    #1;
    chk("a.Y_q", {31'd0, ayq}, sb.pop_front());
    chk("a.chg", {31'd0, achg}, sb.pop_front());
    chk("a.cnt", {16'd0, acnt}, sb.pop_front());
    chk("b.Y_q", {31'd0, byq}, sb.pop_front());
    chk("b.chg", {31'd0, bchg}, sb.pop_front());
    chk("b.cnt", {30'd0, bcnt}, sb.pop_front());
    chk("c.Y_q", {24'd0, cyq}, sb.pop_front());
    chk("c.chg", {31'd0, cchg}, sb.pop_front());
    chk("c.cnt", {16'd0, ccnt}, sb.pop_front());
    if (achg) apulse++;
  endtask

  task automatic cmb(input string tag, input logic [31:0] exp);
    sb.push_back(exp);
    #1;
    chk(tag, {31'd0, ay}, sb.pop_front());
  endtask

  initial begin
    int ev0;
    logic [7:0] tt;
    rst = 1'b1;
    b0 = 0; b1 = 0; bs = 0;
    c0 = 8'hA5; c1 = 8'h3C; cs = 0;

    // Combinational sequence, one change every 10 time units
    a0 = 0; a1 = 0; as = 0; cmb("seq0", 0); ev0 = yev; #9;
    a0 = 1; cmb("seq10", 1); #9;
    as = 1; cmb("seq20", 0); #9;
    a1 = 1; cmb("seq30", 1);
    chk("seq.events", yev - ev0, 3);

    // Truth table indexed by {I0,I1,S0}
    tt = 8'b11011000;
    for (int k = 0; k < 8; k++) begin
      {a0, a1, as} = k[2:0];
      cmb("tt", {31'd0, tt[k]});
    end
    a0 = 1; a1 = 1; as = 0; #1;
    ev0 = yev;
    as = 1; #1; as = 0; #1; as = 1; #1;
    chk("eq.Y", {31'd0, ay}, 1);
    chk("eq.events", yev - ev0, 0);

    cs = 0; #1; chk("c.Y.s0", {24'd0, cy}, 32'hA5);
    cs = 1; #1; chk("c.Y.s1", {24'd0, cy}, 32'h3C);
    cs = 0;

    // Clocked sequence after reset
    a0 = 0; a1 = 0; as = 0;
    tick();
    rst = 1'b0;
    apulse = 0;
    b0 = 1; tick();
    a0 = 1; b0 = 0; cs = 1; tick();
    as = 1; b0 = 1; tick();
    a1 = 1; b0 = 0; tick();
    chk("a.pulses", apulse, 3);
    chk("a.cnt3", {16'd0, acnt}, 3);
    b0 = 1; tick();
    b0 = 0; tick();
    chk("b.sat", {30'd0, bcnt}, 3);
    chk("b.chg.sat", {31'd0, bchg}, 1);

    // Reset mid-run with Y=1
    rst = 1'b1; tick();
    chk("rst.Y", {31'd0, ay}, 1);
    chk("rst.Y_q", {31'd0, ayq}, 0);
    rst = 1'b0; tick();
    chk("rel.Y_q", {31'd0, ayq}, 1);
    chk("rel.chg", {31'd0, achg}, 1);
    chk("rel.cnt", {16'd0, acnt}, 1);
    tick();
    chk("rel.chg.drop", {31'd0, achg}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
